ccff_bitstream_loader: RTL and testbench



---
 rtl/ccff_loader_pkg.sv | 15 +
 rtl/ccff_bitstream_loader_if.sv | 25 ++
 rtl/ccff_piso.sv | 33 +++
 rtl/ccff_bitstream_loader.sv | 113 +++++++++++
 tb/tb_ccff_bitstream_loader.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and defaults for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    localparam int DEF_WORD_W    = 8;
    localparam int DEF_CHAIN_LEN = 64;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE,
        ERROR
    } state_t;

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Word handshake between the bitstream source and the chain loader.
interface ccff_bitstream_loader_if
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic [WORD_W-1:0] cfg_word;
    logic              cfg_parity;
    logic              cfg_valid;
    logic              cfg_ready;

    modport master (
        output cfg_word,
        output cfg_parity,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_word,
        input  cfg_parity,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/ccff_piso.sv
// Parallel-in/serial-out word register with a remaining-bits down-counter.
module ccff_piso #(
    parameter int WORD_W = 8,
    parameter int WB_W   = $clog2(WORD_W + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] din,
    input  logic [WB_W-1:0]   nbits,
    output logic              sout,
    output logic              last
);
    logic [WORD_W-1:0] sreg;
    logic [WB_W-1:0]   word_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            sreg      <= '0;
            word_bits <= '0;
        end else if (load) begin
            sreg      <= din;
            word_bits <= nbits;
        end else if (shift) begin
            sreg      <= {1'b0, sreg[WORD_W-1:1]};
            word_bits <= word_bits - 1'b1;
        end
    end

    assign sout = sreg[0];
    assign last = (word_bits == WB_W'(1));
endmodule

// File: rtl/ccff_bitstream_loader.sv
// Streams configuration words LSB-first into the fabric chain head.
// Optional odd-parity word check: define CCFF_PARITY_CHECK_EN.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                     prog_clk,
    input  logic                     pReset,
    input  logic                     start,
    ccff_bitstream_loader_if.slave   cfg,
    output logic                     ccff_head,
    output logic                     ccff_shift,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [CNT_W-1:0]         bit_count
);
    localparam int WB_W = $clog2(WORD_W + 1);

    state_t          state, state_n;
    logic            accept;
    logic            word_ok;
    logic            restart;
    logic            last;
    logic            ready_q;
    logic [CNT_W:0]  rem;
    logic [WB_W-1:0] nbits;

    assign accept  = (state == LOAD) && cfg.cfg_valid;
    assign restart = start && !(state == LOAD || state == SHIFT);

`ifdef CCFF_PARITY_CHECK_EN
    assign word_ok = ^{cfg.cfg_word, cfg.cfg_parity};
`else
    logic unused_parity;
    assign unused_parity = cfg.cfg_parity;
    assign word_ok       = 1'b1;
`endif

    // The final word is trimmed so the chain never sees more than CHAIN_LEN bits.
    assign rem   = (CNT_W+1)'(CHAIN_LEN) - {1'b0, bit_count};
    assign nbits = (int'(rem) >= WORD_W) ? WB_W'(WORD_W) : WB_W'(rem);

    ccff_piso #(
        .WORD_W (WORD_W),
        .WB_W   (WB_W)
    ) u_piso (
        .clk   (prog_clk),
        .rst   (pReset),
        .load  (accept && word_ok),
        .shift (state == SHIFT),
        .din   (cfg.cfg_word),
        .nbits (nbits),
        .sout  (ccff_head),
        .last  (last)
    );

    always_ff @(posedge prog_clk) begin
        if (pReset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (start) state_n = LOAD;
            LOAD:  if (accept) state_n = word_ok ? SHIFT : ERROR;
            SHIFT: if (last) begin
                state_n = (int'(bit_count) + 1 >= CHAIN_LEN) ? DONE : LOAD;
            end
            DONE:  if (start) state_n = LOAD;
`ifdef CCFF_PARITY_CHECK_EN
            ERROR: if (start) state_n = LOAD;
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            ready_q    <= 1'b0;
            busy       <= 1'b0;
            ccff_shift <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            ready_q    <= (state_n == LOAD);
            busy       <= (state_n == LOAD) || (state_n == SHIFT);
            ccff_shift <= (state_n == SHIFT);
            done       <= (state_n == DONE);
`ifdef CCFF_PARITY_CHECK_EN
            err        <= (state_n == ERROR);
`else
            err        <= 1'b0;
`endif
        end
    end

    assign cfg.cfg_ready = ready_q;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            bit_count <= '0;
        end else if (restart) begin
            bit_count <= '0;
        end else if (state == SHIFT && int'(bit_count) < CHAIN_LEN) begin
            bit_count <= bit_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed plus randomized bench for the configuration-chain loader.
module tb_ccff_bitstream_loader;
    localparam int W  = 8;
    localparam int N  = 20;
    localparam int CW = $clog2(N + 1);
    localparam int NW = (N + W - 1) / W;

    logic          prog_clk = 1'b0;
    logic          pReset   = 1'b1;
    logic          start    = 1'b0;
    logic          ccff_head, ccff_shift, busy, done, err;
    logic [CW-1:0] bit_count;

    ccff_bitstream_loader_if #(.WORD_W(W)) cfg ();

    ccff_bitstream_loader #(
        .WORD_W    (W),
        .CHAIN_LEN (N)
    ) dut (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .start      (start),
        .cfg        (cfg),
        .ccff_head  (ccff_head),
        .ccff_shift (ccff_shift),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bit_count  (bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    int           n_assert = 0;
    int           n_fail   = 0;
    logic [W-1:0] words[NW];
    int           done_cyc, err_cyc, nshift, mono_err, extra;
    logic [N-1:0] got_v;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic par(input logic [W-1:0] w);
        return ~^w;
    endfunction

    // Chain image: bit k of the stream is bit k%W of word k/W.
    function automatic logic [N-1:0] exp_stream();
        logic [N-1:0] v;
        logic [W-1:0] wd;
        for (int k = 0; k < N; k++) begin
            wd   = words[k / W];
            v[k] = wd[k % W];
        end
        return v;
    endfunction

    // Cycle of done: 1 to reach LOAD, then per word stall + 1 + bits.
    function automatic int exp_done(input int stall);
        int c = 1;
        for (int i = 0; i < NW; i++) begin
            c += (i > 0 ? stall : 0) + 1 + ((N - W * i) < W ? (N - W * i) : W);
        end
        return c;
    endfunction

    task automatic run_load(input int stall, input int inj,
                            input int rst_at, input int bad);
        int idx  = 0;
        int wt   = stall;
        int cyc  = 0;
        int prev = 0;
        done_cyc = -1;
        err_cyc  = -1;
        nshift   = 0;
        mono_err = 0;
        got_v    = '0;
        @(negedge prog_clk);
        start         = 1'b1;
        cfg.cfg_valid = 1'b0;
        @(negedge prog_clk);
        start = 1'b0;
        cyc   = 1;
        chk("start_done_clr", done, 0);
        chk("start_cnt_clr", bit_count, 0);
        chk("start_busy", busy, 1);
        while (cyc < 300) begin
            if (int'(bit_count) < prev) mono_err++;
            prev = int'(bit_count);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (err) begin
                err_cyc = cyc;
                break;
            end
            if (ccff_shift) begin
                if (nshift < N) got_v[nshift] = ccff_head;
                nshift++;
                if (nshift == rst_at) begin
                    pReset = 1'b1;
                    break;
                end
            end
            start = (cyc == inj);
            if (cfg.cfg_ready && idx < NW) begin
                if (wt < stall) begin
                    cfg.cfg_valid = 1'b0;
                    wt++;
                end else begin
                    cfg.cfg_valid  = 1'b1;
                    cfg.cfg_word   = words[idx];
                    cfg.cfg_parity = (idx == bad) ? ~par(words[idx])
                                                  : par(words[idx]);
                    idx++;
                    wt = 0;
                end
            end else begin
                cfg.cfg_valid  = (stall == 0);
                cfg.cfg_word   = W'($urandom);
                cfg.cfg_parity = 1'($urandom);
            end
            @(negedge prog_clk);
            cyc++;
        end
        start         = 1'b0;
        cfg.cfg_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        extra = 0;
        cfg.cfg_valid = 1'b1;
        for (int i = 0; i < n; i++) begin
            cfg.cfg_word = W'($urandom);
            @(negedge prog_clk);
            if (ccff_shift) extra++;
        end
        cfg.cfg_valid = 1'b0;
    endtask

    task automatic check_full(input string tag, input int stall);
        chk({tag, "_stream"}, got_v, exp_stream());
        chk({tag, "_nshift"}, nshift, N);
        chk({tag, "_done_cyc"}, done_cyc, exp_done(stall));
        chk({tag, "_count"}, bit_count, N);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_mono"}, mono_err, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        cfg.cfg_word   = '0;
        cfg.cfg_parity = 1'b0;
        cfg.cfg_valid  = 1'b0;
        repeat (3) @(negedge prog_clk);
        chk("rst_ready", cfg.cfg_ready, 0);
        chk("rst_head", ccff_head, 0);
        chk("rst_shift", ccff_shift, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_count", bit_count, 0);
        pReset = 1'b0;

        idle_cycles(4);
        chk("idle_no_shift", extra, 0);
        chk("idle_busy", busy, 0);

        words[0] = 8'hA5;
        words[1] = 8'h3C;
        words[2] = 8'h0F;
        run_load(0, -1, -1, -1);
        check_full("basic", 0);
        chk("basic_literal", got_v, 20'b1111_00111100_10100101);

        idle_cycles(5);
        chk("sat_count", bit_count, N);
        chk("sat_no_shift", extra, 0);
        chk("sat_done", done, 1);

        run_load(5, -1, -1, -1);
        check_full("stall", 5);

        run_load(0, 5, -1, -1);
        check_full("start_busy", 0);

        run_load(0, -1, 11, -1);
        @(negedge prog_clk);
        chk("midrst_shift", ccff_shift, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cfg.cfg_ready, 0);
        chk("midrst_done", done, 0);
        chk("midrst_count", bit_count, 0);
        chk("midrst_head", ccff_head, 0);
        pReset = 1'b0;
        idle_cycles(3);
        chk("midrst_idle", busy, 0);
        chk("midrst_idle_shift", extra, 0);
        run_load(0, -1, -1, -1);
        check_full("reload", 0);

`ifdef CCFF_PARITY_CHECK_EN
        run_load(0, -1, -1, 1);
        chk("par_err_cyc", err_cyc, 11);
        chk("par_err", err, 1);
        chk("par_nshift", nshift, W);
        chk("par_count", bit_count, W);
        idle_cycles(4);
        chk("par_no_shift", extra, 0);
        chk("par_sticky", err, 1);
        run_load(0, -1, -1, -1);
        check_full("par_recover", 0);
`else
        run_load(0, -1, -1, 1);
        check_full("par_ignored", 0);
`endif

        for (int r = 0; r < 6; r++) begin
            int st;
            int inj;
            for (int i = 0; i < NW; i++) words[i] = W'($urandom);
            st  = int'($urandom_range(0, 3));
            inj = int'($urandom_range(2, 20));
            run_load(st, inj, -1, -1);
            check_full($sformatf("rand%0d", r), st);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
